// File: rtl/mv_pkg.sv
// mv_pkg: shared state encoding, data width and BRAM layout
// helpers for the matrix-vector controller.
package mv_pkg;

    localparam int DW = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDVEC = 3'd1,
        S_CALC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // word offset of matrix A inside the data region
    function automatic int mat_ofs();
        return 0;
    endfunction

    // word offset of vector x inside the data region
    function automatic int vec_ofs(input int n);
        return n * n;
    endfunction

    // word offset of result y inside the data region
    function automatic int res_ofs(input int n);
        return n * n + n;
    endfunction

endpackage

// File: rtl/mv_lane.sv
// mv_lane: one int32 multiply-accumulate lane; the
// accumulator restarts from the product on the first term.
module mv_lane
    import mv_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          first_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] acc_o
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] prod;

    // low word of the product is the same signed or unsigned
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (en_i) begin
            acc_d = first_i ? prod : acc_q + prod;
        end
    end

    // accumulator register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mv_array_ctrl.sv
// mv_array_ctrl: y = A*x over an external BRAM using
// NUM_PE MAC lanes, one matrix row per lane per group.
module mv_array_ctrl
    import mv_pkg::*;
#(
    parameter int VECTOR_SIZE = 64,
    parameter int NUM_PE      = 4,
    parameter int BASE_WORD   = 0,
    parameter int VEC_AW      = 6
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_CLK,
    input  logic [31:0] BRAM_RDDATA
);

    localparam int N  = VECTOR_SIZE;
    localparam int NG = N / NUM_PE;
    localparam int CW = VEC_AW + $clog2(NUM_PE) + 1;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [CW-1:0] LD_LAST   = CW'(N);
    localparam logic [CW-1:0] CALC_LAST = CW'(NUM_PE * N);
    localparam logic [CW-1:0] WB_LAST   = CW'(NUM_PE - 1);
    localparam logic [GW-1:0] G_LAST    = GW'(NG - 1);

    state_e state_q;
    state_e state_d;

    logic [CW-1:0]     cnt_q;
    logic [GW-1:0]     g_q;
    logic [VEC_AW-1:0] k;
    logic [CW-1:0]     p;
    logic              issue_ld;
    logic              issue_mac;
    logic [29:0]       word;

    logic              pend_ld_q;
    logic              pend_mac_q;
    logic              pend_first_q;
    logic [VEC_AW-1:0] pend_k_q;
    logic [CW-1:0]     pend_p_q;

    logic [DW-1:0] vram [N];
    logic [DW-1:0] vrd_q;
    logic [DW-1:0] acc [NUM_PE];

    assign BRAM_CLK  = aclk;
    assign k         = cnt_q[VEC_AW-1:0];
    assign p         = cnt_q >> VEC_AW;
    assign issue_ld  = (state_q == S_LDVEC) && (cnt_q < LD_LAST);
    assign issue_mac = (state_q == S_CALC) && (cnt_q < CALC_LAST);
    assign BRAM_ADDR = {word, 2'b00};

    // state, per-state step counter and row-group counter
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == S_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == S_IDLE) begin
                g_q <= '0;
            end else if (state_q == S_WB && state_d == S_CALC) begin
                g_q <= g_q + GW'(1);
            end
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LDVEC;
            S_LDVEC: if (cnt_q == LD_LAST) state_d = S_CALC;
            S_CALC:  if (cnt_q == CALC_LAST) state_d = S_WB;
            S_WB: begin
                if (cnt_q == WB_LAST) begin
                    state_d = (g_q == G_LAST) ? S_DONE : S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // BRAM address, write strobe, write data and status outputs
    always_comb begin
        word        = '0;
        BRAM_WE     = '0;
        BRAM_WRDATA = '0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        unique case (state_q)
            S_LDVEC: begin
                if (issue_ld) begin
                    word = 30'(BASE_WORD) + 30'(vec_ofs(N))
                         + 30'(cnt_q);
                end
            end
            S_CALC: begin
                if (issue_mac) begin
                    word = 30'(BASE_WORD) + 30'(mat_ofs())
                         + 30'(g_q) * 30'(NUM_PE * N)
                         + 30'(cnt_q);
                end
            end
            S_WB: begin
                word = 30'(BASE_WORD) + 30'(res_ofs(N))
                     + 30'(g_q) * 30'(NUM_PE)
                     + 30'(cnt_q);
                BRAM_WE = 4'hF;
                for (int i = 0; i < NUM_PE; i++) begin
                    if (cnt_q == CW'(i)) BRAM_WRDATA = acc[i];
                end
            end
            default: ;
        endcase
    end

    // tag each issued read so its data lands correctly next cycle
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pend_ld_q    <= 1'b0;
            pend_mac_q   <= 1'b0;
            pend_first_q <= 1'b0;
            pend_k_q     <= '0;
            pend_p_q     <= '0;
        end else begin
            pend_ld_q    <= issue_ld;
            pend_mac_q   <= issue_mac;
            pend_first_q <= (k == '0);
            pend_k_q     <= k;
            pend_p_q     <= p;
        end
    end

    // vector RAM: filled during load, read by k during compute
    always_ff @(posedge aclk) begin
        if (pend_ld_q) vram[pend_k_q] <= BRAM_RDDATA;
        vrd_q <= vram[k];
    end

    for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
        mv_lane u_lane (
            .clk_i   (aclk),
            .rst_ni  (aresetn),
            .en_i    (pend_mac_q && (pend_p_q == CW'(l))),
            .first_i (pend_first_q),
            .a_i     (BRAM_RDDATA),
            .b_i     (vrd_q),
            .acc_o   (acc[l])
        );
    end

endmodule

// File: tb/tb_mv_array_ctrl.sv
// tb_mv_array_ctrl: directed vectors and corner sequences
// for four controller configurations sharing one clock.
module tb_mv_array_ctrl;

    localparam int ND = 4;
    localparam int NS  [ND] = '{4, 4, 8, 8};
    localparam int PS  [ND] = '{2, 4, 8, 1};
    localparam int BS  [ND] = '{0, 0, 0, 16};
    localparam int AWS [ND] = '{2, 2, 3, 3};
    localparam int LIM = 500;

    typedef struct packed {
        int               d;
        int               kind;
        logic [7:0][31:0] x;
        logic [7:0][31:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic aresetn;
    logic start [ND];
    logic busy  [ND];
    logic done  [ND];
    logic bclk  [ND];
    logic [31:0] addr [ND];
    logic [31:0] wdat [ND];
    logic [31:0] rdat [ND];
    logic [3:0]  we   [ND];
    logic [31:0] mem  [ND][256];

    logic        ld_en;
    int          ld_d;
    int          ld_a;
    logic [31:0] ld_v;

    int   tests = 0;
    int   fails = 0;
    int   wr_cnt  [ND];
    int   bursts  [ND];
    logic we_prev [ND];
    logic mon_en;

    always #5 clk = ~clk;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        mv_array_ctrl #(
            .VECTOR_SIZE (NS[i]),
            .NUM_PE      (PS[i]),
            .BASE_WORD   (BS[i]),
            .VEC_AW      (AWS[i])
        ) u_dut (
            .aclk        (clk),
            .aresetn     (aresetn),
            .start       (start[i]),
            .busy        (busy[i]),
            .done        (done[i]),
            .BRAM_ADDR   (addr[i]),
            .BRAM_WRDATA (wdat[i]),
            .BRAM_WE     (we[i]),
            .BRAM_CLK    (bclk[i]),
            .BRAM_RDDATA (rdat[i])
        );
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_d][ld_a] <= ld_v;
        for (int i = 0; i < ND; i++) begin
            if (we[i] != 4'h0) mem[i][addr[i][9:2]] <= wdat[i];
            rdat[i] <= mem[i][addr[i][9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            for (int i = 0; i < ND; i++) begin
                if (we[i] != 4'h0) begin
                    chk($sformatf("we_ctl%0d", i),
                        {26'b0, busy[i], done[i], we[i]}, 32'h2F);
                    wr_cnt[i]++;
                    if (!we_prev[i]) bursts[i]++;
                end
                if (!busy[i] || done[i])
                    chk($sformatf("idle_addr%0d", i), addr[i], 32'h0);
                we_prev[i] = (we[i] != 4'h0);
            end
        end
    endtask

    task automatic poke(input int d, input int a, input logic [31:0] v);
        ld_en = 1'b1;
        ld_d  = d;
        ld_a  = a;
        ld_v  = v;
        tick();
        ld_en = 1'b0;
    endtask

    function automatic logic [31:0] aval(int kind, int i, int j);
        case (kind)
            0:       return (i == j) ? 32'd1 : 32'd0;
            1:       return 32'(i + j);
            2:       return 32'h4000_0000;
            3:       return 32'(i - j);
            default: return $urandom;
        endcase
    endfunction

    task automatic fill(input int d, input int kind,
                        input logic [7:0][31:0] x);
        int n;
        int b;
        n = NS[d];
        b = BS[d];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                poke(d, b + i * n + j, aval(kind, i, j));
        for (int k = 0; k < n; k++)
            poke(d, b + n * n + k, (kind == 4) ? $urandom : x[k]);
        for (int k = 0; k < n; k++)
            poke(d, b + n * n + n + k, 32'hDEAD_BEEF);
    endtask

    function automatic logic [7:0][31:0] golden(int d);
        logic [7:0][31:0] r;
        logic [31:0]      acc;
        int n;
        int b;
        n = NS[d];
        b = BS[d];
        r = '0;
        for (int i = 0; i < n; i++) begin
            acc = '0;
            for (int j = 0; j < n; j++)
                acc += mem[d][b + i * n + j] * mem[d][b + n * n + j];
            r[i] = acc;
        end
        return r;
    endfunction

    function automatic int exp_lat(int d);
        int n;
        int p;
        n = NS[d];
        p = PS[d];
        return (n + 1) + (n / p) * (p * n + 1 + p) + 1;
    endfunction

    function automatic logic [7:0][31:0] pk(int a0, int a1, int a2,
        int a3, int a4, int a5, int a6, int a7);
        logic [7:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    function automatic vec_t mkv(int d, int kind,
        logic [7:0][31:0] x, logic [7:0][31:0] y);
        vec_t v;
        v.d    = d;
        v.kind = kind;
        v.x    = x;
        v.y    = y;
        return v;
    endfunction

    task automatic run(input int d, input int rp, output int lat);
        start[d] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            start[d] = (lat == rp);
        end while (!done[d] && lat < LIM);
        start[d] = 1'b0;
    endtask

    task automatic chk_y(input int d, input logic [7:0][31:0] y,
                         input string nm);
        int n;
        n = NS[d];
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_y%0d", nm, k),
                mem[d][BS[d] + n * n + n + k], y[k]);
    endtask

    task automatic run_chk(input int d, input logic [7:0][31:0] y,
                           input string nm, input int rp);
        int lat;
        int w0;
        int b0;
        w0 = wr_cnt[d];
        b0 = bursts[d];
        run(d, rp, lat);
        chk({nm, "_lat"}, lat, exp_lat(d));
        chk({nm, "_writes"}, wr_cnt[d] - w0, NS[d]);
        chk({nm, "_bursts"}, bursts[d] - b0, NS[d] / PS[d]);
        chk_y(d, y, nm);
    endtask

    vec_t             tbl [6];
    logic [7:0][31:0] y4;
    logic [7:0][31:0] yneg;
    logic [7:0][31:0] yg;
    int               lat;

    initial begin
        tbl[0] = mkv(0, 0, pk(1, 2, 3, 4, 0, 0, 0, 0),
                     pk(1, 2, 3, 4, 0, 0, 0, 0));
        tbl[1] = mkv(0, 1, pk(1, -1, 2, -2, 0, 0, 0, 0),
                     pk(-3, -3, -3, -3, 0, 0, 0, 0));
        tbl[2] = mkv(1, 2, pk(4, 4, 4, 4, 0, 0, 0, 0),
                     pk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl[3] = mkv(0, 3, pk(1, 2, 3, 4, 0, 0, 0, 0),
                     pk(-20, -10, 0, 10, 0, 0, 0, 0));
        tbl[4] = mkv(2, 3, pk(1, 1, 1, 1, 1, 1, 1, 1),
                     pk(-28, -20, -12, -4, 4, 12, 20, 28));
        tbl[5] = mkv(3, 3, pk(1, 1, 1, 1, 1, 1, 1, 1),
                     pk(-28, -20, -12, -4, 4, 12, 20, 28));
        y4   = pk(1, 2, 3, 4, 0, 0, 0, 0);
        yneg = pk(-3, -3, -3, -3, 0, 0, 0, 0);

        mon_en  = 1'b0;
        aresetn = 1'b0;
        ld_en   = 1'b0;
        ld_d    = 0;
        ld_a    = 0;
        ld_v    = '0;
        for (int i = 0; i < ND; i++) begin
            start[i]   = 1'b0;
            wr_cnt[i]  = 0;
            bursts[i]  = 0;
            we_prev[i] = 1'b0;
        end
        tick();
        tick();
        chk("rst_busy", {31'b0, busy[0]}, 0);
        chk("rst_done", {31'b0, done[0]}, 0);
        chk("rst_we", {28'b0, we[0]}, 0);
        chk("rst_addr", addr[0], 0);
        chk("rst_wdata", wdat[0], 0);
        aresetn = 1'b1;
        mon_en  = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            fill(tbl[v].d, tbl[v].kind, tbl[v].x);
            run_chk(tbl[v].d, tbl[v].y, $sformatf("vec%0d", v), -1);
        end

        // start pulsed again in the middle of the compute phase
        fill(0, 0, y4);
        run_chk(0, y4, "repulse", 10);
        tick();
        tick();
        chk("repulse_idle", {31'b0, busy[0]}, 0);

        // start held high across done
        fill(0, 0, pk(5, 6, 7, 8, 0, 0, 0, 0));
        start[0] = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done[0] && lat < LIM);
        chk("hold_lat1", lat, 28);
        tick();
        chk("hold_idle", {31'b0, busy[0]}, 0);
        tick();
        chk("hold_rerun", {31'b0, busy[0]}, 1);
        start[0] = 1'b0;
        lat = 2;
        do begin
            tick();
            lat++;
        end while (!done[0] && lat < LIM);
        chk("hold_gap", lat, 29);
        chk_y(0, pk(5, 6, 7, 8, 0, 0, 0, 0), "hold");

        // reset during the first write-back burst
        fill(0, 1, pk(1, -1, 2, -2, 0, 0, 0, 0));
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        lat = 0;
        while (we[0] == 4'h0 && lat < LIM) begin
            tick();
            lat++;
        end
        chk("rst_mid_wb", {28'b0, we[0]}, 32'hF);
        aresetn = 1'b0;
        tick();
        chk("rst_mid_busy", {31'b0, busy[0]}, 0);
        chk("rst_mid_we", {28'b0, we[0]}, 0);
        chk("rst_mid_done", {31'b0, done[0]}, 0);
        chk("rst_mid_addr", addr[0], 0);
        aresetn = 1'b1;
        tick();
        fill(0, 1, pk(1, -1, 2, -2, 0, 0, 0, 0));
        run_chk(0, yneg, "rst_rerun", -1);

        // random matrices against the golden model
        for (int d = 2; d < ND; d++) begin
            fill(d, 4, '0);
            yg = golden(d);
            run_chk(d, yg, $sformatf("rand%0d", d), -1);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
